// File: rtl/cl_adaptor_pkg.sv
// Shared types for the cache-line to 64-bit burst adaptor.
// Line/beat geometry and adaptor FSM states.
package cl_adaptor_pkg;

    localparam int S_LINE     = 256;
    localparam int S_BURST    = 64;
    localparam int NUM_BEATS  = S_LINE / S_BURST;
    localparam int BEAT_IDX_W = $clog2(NUM_BEATS);
    localparam int S_OFFSET   = 5;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } cl_state_t;

    typedef logic [S_LINE-1:0]     line_t;
    typedef logic [S_BURST-1:0]    beat_t;
    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return {a[31:S_OFFSET], {S_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit line request into a 4-beat 64-bit memory burst,
// then answers the cache with a single-cycle pmem_resp.
module cacheline_adaptor
    import cl_adaptor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pmem_address,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  line_t       pmem_wdata,
    output line_t       pmem_rdata,
    output logic        pmem_resp,
    output logic [31:0] burst_address,
    output logic        burst_read,
    output logic        burst_write,
    output beat_t       burst_wdata,
    input  beat_t       burst_rdata,
    input  logic        burst_resp
);

    cl_state_t state;
    beat_idx_t count;
    line_t     line;
    beat_idx_t count_nxt;
    logic      last;

    assign count_nxt = count + beat_idx_t'(1);
    assign last      = (count == beat_idx_t'(NUM_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            line          <= '0;
            pmem_rdata    <= '0;
            pmem_resp     <= 1'b0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_wdata   <= '0;
        end else begin
            pmem_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pmem_write) begin
                        line          <= pmem_wdata;
                        burst_wdata   <= pmem_wdata[S_BURST-1:0];
                        burst_address <= line_align(pmem_address);
                        burst_write   <= 1'b1;
                        state         <= WRITE;
                    end else if (pmem_read) begin
                        burst_address <= line_align(pmem_address);
                        burst_read    <= 1'b1;
                        state         <= READ;
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        line[count*S_BURST +: S_BURST] <= burst_rdata;
                        count <= count_nxt;
                        if (last) begin
                            // final beat lands in the top slot
                            pmem_rdata <= {burst_rdata,
                                           line[S_LINE-S_BURST-1:0]};
                            burst_read <= 1'b0;
                            pmem_resp  <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (burst_resp) begin
                        count       <= count_nxt;
                        burst_wdata <= line[count_nxt*S_BURST +: S_BURST];
                        if (last) begin
                            burst_write <= 1'b0;
                            pmem_resp   <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: acts as cache and memory,
// queueing expected lines/beats and comparing as the DUT produces them.
module tb_cacheline_adaptor;
    import cl_adaptor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    line_t       pmem_wdata;
    line_t       pmem_rdata;
    logic        pmem_resp;
    logic [31:0] burst_address;
    logic        burst_read;
    logic        burst_write;
    beat_t       burst_wdata;
    beat_t       burst_rdata;
    logic        burst_resp;

    int n_chk  = 0;
    int n_pass = 0;

    line_t rd_q[$];
    beat_t wr_q[$];

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_address(burst_address),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic push_write(input line_t l);
        for (int i = 0; i < NUM_BEATS; i++) wr_q.push_back(l[i*64 +: 64]);
    endtask

    // Called at the negedge after the request edge; returns at the
    // negedge where pmem_resp must be high.
    task automatic serve(input logic wr, input line_t rl,
                         input int gap_at, input int gap_len);
        for (int i = 0; i < NUM_BEATS; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    burst_resp = 1'b0;
                    @(negedge clk);
                    chk("gap_req", wr ? burst_write : burst_read, 1);
                    chk("gap_resp", pmem_resp, 0);
                    if (wr && wr_q.size() > 0)
                        chk("gap_wdata", burst_wdata, wr_q[0]);
                end
            end
            chk("beat_req", wr ? burst_write : burst_read, 1);
            chk("early_resp", pmem_resp, 0);
            if (wr) begin
                if (wr_q.size() == 0) chk("wr_q_empty", 1, 0);
                else chk("wdata", burst_wdata, wr_q.pop_front());
            end
            burst_resp  = 1'b1;
            burst_rdata = wr ? 64'h0 : rl[i*64 +: 64];
            @(negedge clk);
        end
        burst_resp = 1'b0;
        chk("resp", pmem_resp, 1);
        chk("req_drop", wr ? burst_write : burst_read, 0);
        if (!wr) begin
            if (rd_q.size() == 0) chk("rd_q_empty", 1, 0);
            else chk("rdata", pmem_rdata, rd_q.pop_front());
        end
    endtask

    task automatic start_read(input logic [31:0] a, input line_t l);
        rd_q.push_back(l);
        pmem_address = a;
        pmem_read    = 1'b1;
        @(negedge clk);
        chk("rd_addr", burst_address, {a[31:5], 5'b0});
    endtask

    task automatic end_resp();
        @(negedge clk);
        chk("resp_pulse", pmem_resp, 0);
    endtask

    line_t l1, l2, lw, lb;

    initial begin
        rst = 1'b1; pmem_address = '0; pmem_read = 0; pmem_write = 0;
        pmem_wdata = '0; burst_rdata = '0; burst_resp = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", pmem_rdata, 0);
        chk("rst_resp", pmem_resp, 0);
        chk("rst_addr", burst_address, 0);
        chk("rst_brd", burst_read, 0);
        chk("rst_bwr", burst_write, 0);
        chk("rst_wdata", burst_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // reset during beat 2 of a read
        pmem_read = 1'b1; pmem_address = 32'h0000_4000;
        @(negedge clk);
        chk("mr_req", burst_read, 1);
        for (int i = 0; i < 2; i++) begin
            burst_resp = 1'b1; burst_rdata = {8{8'h90 + 8'(i)}};
            @(negedge clk);
        end
        burst_rdata = {8{8'h92}}; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; burst_resp = 1'b0; pmem_read = 1'b0;
        chk("mr_drop", burst_read, 0);
        chk("mr_resp", pmem_resp, 0);
        chk("mr_rdata", pmem_rdata, 0);
        chk("mr_state", dut.state, IDLE);
        chk("mr_count", dut.count, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mr_noresp", pmem_resp, 0);
        end

        // minimum-latency read
        l1 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        start_read(32'h0000_1234, l1);
        chk("rd_align", burst_address, 32'h0000_1220);
        serve(1'b0, l1, -1, 0);
        pmem_read = 1'b0;
        end_resp();

        // write with a 3-cycle gap between beats 1 and 2
        lw = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        push_write(lw);
        pmem_wdata = lw; pmem_address = 32'h0000_8F3C; pmem_write = 1'b1;
        @(negedge clk);
        pmem_wdata = ~lw; pmem_address = 32'hFFFF_FFFF;
        chk("wr_addr", burst_address, 32'h0000_8F20);
        serve(1'b1, '0, 2, 3);
        pmem_write = 1'b0;
        chk("rdata_kept", pmem_rdata, l1);
        end_resp();

        // simultaneous read and write: write first, then read
        lb = rand_line(); l2 = rand_line();
        push_write(lb);
        pmem_wdata = lb; pmem_address = 32'h1000_0040;
        pmem_write = 1'b1; pmem_read = 1'b1;
        rd_q.push_back(l2);
        @(negedge clk);
        chk("both_wr", burst_write, 1);
        chk("both_nord", burst_read, 0);
        serve(1'b1, '0, -1, 0);
        pmem_write = 1'b0;
        end_resp();
        chk("both_idle", burst_read, 0);
        @(negedge clk);
        chk("both_rd", burst_read, 1);
        serve(1'b0, l2, 1, 1);
        pmem_read = 1'b0;
        end_resp();

        // spurious burst_resp in IDLE
        burst_resp = 1'b1; burst_rdata = {4{16'hDEAD}};
        repeat (3) begin
            @(negedge clk);
            chk("sp_resp", pmem_resp, 0);
            chk("sp_state", dut.state, IDLE);
            chk("sp_count", dut.count, 0);
            chk("sp_req", burst_read | burst_write, 0);
        end
        burst_resp = 1'b0;

        // back-to-back reads with request held high
        l1 = rand_line(); l2 = rand_line();
        start_read(32'h0ABC_0067, l1);
        serve(1'b0, l1, -1, 0);
        rd_q.push_back(l2);
        pmem_address = 32'h0ABC_00A0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_req", burst_read, 1);
        chk("b2b_addr", burst_address, 32'h0ABC_00A0);
        serve(1'b0, l2, 3, 2);
        pmem_read = 1'b0;
        end_resp();

        // randomised reads and writes
        for (int k = 0; k < 6; k++) begin
            int ga, gl;
            logic [31:0] a;
            ga = int'($urandom_range(3, 0));
            gl = int'($urandom_range(2, 0));
            a  = $urandom;
            l1 = rand_line();
            if (k % 2 == 1) begin
                push_write(l1);
                pmem_wdata = l1; pmem_address = a; pmem_write = 1'b1;
                @(negedge clk);
                chk("rnd_waddr", burst_address, {a[31:5], 5'b0});
                serve(1'b1, '0, ga, gl);
                pmem_write = 1'b0;
            end else begin
                start_read(a, l1);
                serve(1'b0, l1, ga, gl);
                pmem_read = 1'b0;
            end
            end_resp();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end

endmodule
